// File: rtl/ws281x_code.sv
// ws281x_code: WS281x bit-waveform encoder.
//
// Turns each accepted bit into one symbol on the LED line. The line is high
// for the latched high time, then low until tim_sum_in cycles have elapsed.
// The block also produces the low latch/reset period between frames.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line low, waiting for bit_rdy_in or rst_req_in
// BIT   | sending one symbol; cnt_q is the cycle index j within the bit
// RST   | line held low; rcnt_q counts down to the last latch cycle
//
// Ports:
//   clk_in, rst_n_in           clock, async active-low reset
//   bit_rdy_in, bit_data_in    new-bit strobe and its value
//   t0h_cnt_in, t1h_cnt_in     high time for 0 / 1 bits (clk cycles)
//   tim_sum_in                 bit period; held stable for the whole bit
//   rst_req_in, rst_cnt_in     latch-period strobe and length
//   bit_code_out               registered serial line
//   bit_done_out, rst_done_out high in the last cycle of a bit / latch period
//   busy_out                   state != IDLE
//   proto_err_out              sticky protocol error (WS281X_CODE_ERR_EN only)
//
// Build option: define WS281X_CODE_ERR_EN to enable proto_err_out; without it
// the output is tied low.

module ws281x_code #(
  parameter int RST_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             bit_rdy_in,
  input  logic             bit_data_in,
  input  logic [7:0]       t0h_cnt_in,
  input  logic [7:0]       t1h_cnt_in,
  input  logic [7:0]       tim_sum_in,
  input  logic             rst_req_in,
  input  logic [RST_W-1:0] rst_cnt_in,
  output logic             bit_code_out,
  output logic             bit_done_out,
  output logic             rst_done_out,
  output logic             busy_out,
  output logic             proto_err_out
);

  typedef enum logic [1:0] {IDLE, BIT, RST} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       th_q, th_d;
  logic [RST_W-1:0] rcnt_q, rcnt_d;
  logic             code_q, code_d;

  logic [8:0] period;
  logic [8:0] cnt_next9;
  logic [7:0] th_new;
  logic       bit_done, rst_done, accept;

  // A zero period is treated as a one-cycle bit.
  assign period    = (tim_sum_in == 8'd0) ? 9'd1 : {1'b0, tim_sum_in};
  assign cnt_next9 = {1'b0, cnt_q} + 9'd1;
  // >= rather than == so a period shortened mid-bit cannot strand the counter.
  assign bit_done  = (state_q == BIT) && (cnt_next9 >= period);
  assign rst_done  = (state_q == RST) && (rcnt_q == '0);
  assign accept    = (state_q == IDLE) || bit_done || rst_done;
  assign th_new    = bit_data_in ? t1h_cnt_in : t0h_cnt_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    th_d    = th_q;
    rcnt_d  = rcnt_q;
    code_d  = 1'b0;
    if (accept) begin
      if (bit_rdy_in) begin
        state_d = BIT;
        th_d    = th_new;
        cnt_d   = 8'd0;
        code_d  = (th_new != 8'd0);
      end else if (rst_req_in) begin
        state_d = RST;
        // Down-counter loaded with R-1 so terminal count marks the last cycle.
        rcnt_d  = (rst_cnt_in == '0) ? '0 : rst_cnt_in - RST_W'(1);
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == BIT) begin
      cnt_d  = cnt_q + 8'd1;
      code_d = (cnt_next9 < {1'b0, th_q});
    end else if (state_q == RST) begin
      rcnt_d = rcnt_q - RST_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      th_q    <= 8'd0;
      rcnt_q  <= '0;
      code_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      th_q    <= th_d;
      rcnt_q  <= rcnt_d;
      code_q  <= code_d;
    end
  end

`ifdef WS281X_CODE_ERR_EN
  logic err_q, err_d;

  // Busy-cycle requests and a rst_req_in dropped in favour of a bit are errors.
  always_comb begin
    err_d = err_q
          | ((bit_rdy_in | rst_req_in) & ~accept)
          | (accept & bit_rdy_in & rst_req_in);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) err_q <= 1'b0;
    else           err_q <= err_d;
  end

  assign proto_err_out = err_q;
`else
  assign proto_err_out = 1'b0;
`endif

  assign bit_code_out = code_q;
  assign bit_done_out = bit_done;
  assign rst_done_out = rst_done;
  assign busy_out     = (state_q != IDLE);

endmodule

// File: tb/tb_ws281x_code.sv
module tb_ws281x_code;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        bit_rdy_in = 1'b0;
  logic        bit_data_in = 1'b0;
  logic [7:0]  t0h_cnt_in = 8'd0;
  logic [7:0]  t1h_cnt_in = 8'd0;
  logic [7:0]  tim_sum_in = 8'd0;
  logic        rst_req_in = 1'b0;
  logic [15:0] rst_cnt_in = 16'd0;
  logic        bit_code_out, bit_done_out, rst_done_out, busy_out, proto_err_out;

  int n_cmp = 0;
  int n_bad = 0;
  int err_exp;

  ws281x_code #(.RST_W(16)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .bit_rdy_in   (bit_rdy_in),
    .bit_data_in  (bit_data_in),
    .t0h_cnt_in   (t0h_cnt_in),
    .t1h_cnt_in   (t1h_cnt_in),
    .tim_sum_in   (tim_sum_in),
    .rst_req_in   (rst_req_in),
    .rst_cnt_in   (rst_cnt_in),
    .bit_code_out (bit_code_out),
    .bit_done_out (bit_done_out),
    .rst_done_out (rst_done_out),
    .busy_out     (busy_out),
    .proto_err_out(proto_err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Called in cycle j=0 of a bit; returns in cycle j=p-1 without ticking.
  // A bit_rdy_in (data 1) is injected at cycle inj when inj >= 0.
  task automatic observe(input int p, input int th, input int inj, input string tag);
    int bad = 0, hi = 0, done_n = 0, done_at = -1;
    for (int j = 0; j < p; j++) begin
      if (bit_code_out !== (j < th)) bad++;
      if (bit_code_out) hi++;
      if (bit_done_out) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
      if (rst_done_out !== 1'b0) bad++;
      if (busy_out !== 1'b1) bad++;
      if (j < p - 1) begin
        if (j == inj) begin
          bit_rdy_in  = 1'b1;
          bit_data_in = 1'b1;
        end
        tick();
        bit_rdy_in = 1'b0;
      end
    end
    chk({tag, ".shape_errs"}, bad, 0);
    chk({tag, ".high_cycles"}, hi, (th < p) ? th : p);
    chk({tag, ".done_count"}, done_n, 1);
    chk({tag, ".done_at"}, done_at, p - 1);
  endtask

  task automatic start_bit(input logic d, input int t0h, input int t1h, input int ts);
    bit_data_in = d;
    t0h_cnt_in  = 8'(t0h);
    t1h_cnt_in  = 8'(t1h);
    tim_sum_in  = 8'(ts);
    bit_rdy_in  = 1'b1;
    tick();
    bit_rdy_in  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".busy"}, busy_out, 0);
    chk({tag, ".code"}, bit_code_out, 0);
    chk({tag, ".done"}, bit_done_out, 0);
  endtask

  initial begin
`ifdef WS281X_CODE_ERR_EN
    err_exp = 1;
`else
    err_exp = 0;
`endif
    // Reset
    #2 rst_n_in = 1'b0;
    #1;
    chk("rst.code", bit_code_out, 0);
    chk("rst.done", bit_done_out, 0);
    chk("rst.rdone", rst_done_out, 0);
    chk("rst.busy", busy_out, 0);
    chk("rst.err", proto_err_out, 0);
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    tick();

    // Single 0 bit: 8H/17L
    start_bit(1'b0, 8, 16, 25);
    observe(25, 8, -1, "bit0");
    tick();
    check_idle("bit0.after");

    // 1 bit followed back-to-back by a 0 bit
    start_bit(1'b1, 8, 16, 25);
    observe(25, 16, -1, "b2b.first");
    bit_rdy_in  = 1'b1;
    bit_data_in = 1'b0;
    tick();
    bit_rdy_in  = 1'b0;
    observe(25, 8, -1, "b2b.second");
    tick();
    check_idle("b2b.after");

    // Boundaries
    start_bit(1'b0, 0, 16, 10);
    observe(10, 0, -1, "th0");
    tick();
    start_bit(1'b1, 8, 30, 20);
    observe(20, 30, -1, "thbig");
    tick();
    start_bit(1'b0, 8, 16, 0);
    observe(1, 8, -1, "ts0");
    tick();
    check_idle("ts0.after");

    // Latch period of 2500 cycles, then a bit accepted in its last cycle
    rst_cnt_in = 16'd2500;
    rst_req_in = 1'b1;
    tick();
    rst_req_in = 1'b0;
    begin
      int bad = 0, rd_n = 0, rd_at = -1;
      for (int j = 0; j < 2500; j++) begin
        if (bit_code_out !== 1'b0) bad++;
        if (bit_done_out !== 1'b0) bad++;
        if (busy_out !== 1'b1) bad++;
        if (rst_done_out) begin
          rd_n++;
          if (rd_at < 0) rd_at = j;
        end
        if (j < 2499) tick();
      end
      chk("latch.shape_errs", bad, 0);
      chk("latch.rdone_count", rd_n, 1);
      chk("latch.rdone_at", rd_at, 2499);
    end
    start_bit(1'b1, 8, 16, 25);
    observe(25, 16, -1, "after_latch");
    tick();
    check_idle("after_latch.idle");

    // Request in a busy, non-accept cycle is ignored
    start_bit(1'b0, 8, 16, 25);
    observe(25, 8, 5, "ignored");
    tick();
    check_idle("ignored.after");
    chk("ignored.err", proto_err_out, err_exp);

    // Reset mid-bit at j=3 while the line is high
    start_bit(1'b1, 8, 16, 25);
    repeat (3) tick();
    chk("midrst.pre_code", bit_code_out, 1);
    rst_n_in = 1'b0;
    #1;
    chk("midrst.code", bit_code_out, 0);
    chk("midrst.busy", busy_out, 0);
    chk("midrst.err", proto_err_out, 0);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    tick();
    start_bit(1'b0, 8, 16, 25);
    observe(25, 8, -1, "midrst.next");
    tick();
    check_idle("midrst.after");

    // Simultaneous bit + latch request: bit wins, no latch period follows
    rst_cnt_in = 16'd5;
    rst_req_in = 1'b1;
    start_bit(1'b0, 8, 16, 25);
    rst_req_in = 1'b0;
    observe(25, 8, -1, "simul");
    tick();
    check_idle("simul.after");
    chk("simul.rdone", rst_done_out, 0);
    chk("simul.err", proto_err_out, err_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ws281x_code.md
Name: ws281x_code

Overview:
- Bit-waveform encoder that sits directly downstream of the per-bit timing-configuration stage (ws281x_conf).
- Converts each accepted bit into one WS281x symbol on the serial LED line.
- The line is high for T0H/T1H clock cycles, then low until a total period of tim_sum cycles has elapsed.
- Also generates the latch/reset low period between frames, and handshakes with the upstream bit serializer through bit_done_out / rst_done_out.

Parameters:
- RST_W, 16, width of rst_cnt_in and of the internal reset-period counter.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst_n_in  input  1  asynchronous active-low reset.
- bit_rdy_in  input  1  one-cycle strobe: new bit available (same strobe drives ws281x_conf).
- bit_data_in  input  1  bit value, valid with bit_rdy_in.
- t0h_cnt_in  input  8  high time for a 0 bit, in clk cycles.
- t1h_cnt_in  input  8  high time for a 1 bit, in clk cycles.
- tim_sum_in  input  8  bit period from ws281x_conf; valid from the cycle after bit_rdy_in.
- rst_req_in  input  1  one-cycle strobe: request a latch/reset period.
- rst_cnt_in  input  RST_W  latch period length in clk cycles, sampled with rst_req_in.
- bit_code_out  output  1  serial LED data line (registered).
- bit_done_out  output  1  high in the last cycle of a bit period.
- rst_done_out  output  1  high in the last cycle of a reset period.
- busy_out  output  1  high whenever state != IDLE.
- proto_err_out  output  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n_in low): state=IDLE, all counters 0; bit_code_out, bit_done_out, rst_done_out, busy_out, proto_err_out all 0. Reset mid-bit or mid-latch aborts immediately and the line goes low.
- States: IDLE, BIT, RST.
- Accept point: IDLE, or the final cycle of BIT/RST (i.e., the cycle where bit_done_out or rst_done_out is high).
- bit_rdy_in at an accept point:
  - latch th = bit_data_in ? t1h_cnt_in : t0h_cnt_in;
  - cnt <= 0; go to BIT.
  - Cycles of the bit are numbered j = 0 .. P-1, where j=0 is the first cycle after the accepting edge.
- In BIT, cycle j:
  - bit_code_out = (j < th);
  - P = max(tim_sum_in, 1), using 9-bit compare; tim_sum_in must stay stable for the whole bit.
  - bit_done_out = (j == P-1).
  - th=0 gives a line that is low for the whole period; th>=P gives a line that is high for the whole period.
- End of BIT (j == P-1): go to IDLE, unless a new request is accepted in that cycle. Accepting a new bit there gives back-to-back bits with no gap cycle.
- rst_req_in at an accept point (and bit_rdy_in low):
  - latch R = max(rst_cnt_in, 1); go to RST.
  - bit_code_out = 0 for exactly R cycles; rst_done_out is high in the last of them.
- Simultaneous bit_rdy_in and rst_req_in: bit_rdy_in wins; rst_req_in is dropped and counts as an error.
- Requests arriving in a non-accept busy cycle are ignored. Line timing is unaffected.
- bit_done_out, rst_done_out: exactly one cycle per completed period; never both high in the same cycle.
- busy_out is combinational from the state register. It is high throughout BIT/RST, including the final cycle.

Optional Feature:
- Macro WS281X_CODE_ERR_EN.
- Defined: proto_err_out is set and stays set until rst_n_in when any of the following occurs:
  - bit_rdy_in or rst_req_in is high in a non-accept busy cycle;
  - rst_req_in is dropped by a simultaneous bit_rdy_in.
- Not defined: proto_err_out is tied 0 and no error logic is synthesized.
- Line behaviour is identical in both builds.

Test Plan:
- Reset, then bit_rdy_in=1, bit_data_in=0, t0h=8, tim_sum=25 -> line high 8 cycles, low 17 cycles; bit_done_out high at j=24 only; busy_out low afterwards.
- Bit 1 with t1h=16, tim_sum=25, then a second bit_rdy_in (data 0, t0h=8) in the bit_done_out cycle -> 16H/9L immediately followed by 8H/17L, no gap cycle.
- Boundaries:
  - th=0, tim_sum=10 -> line low for 10 cycles, then bit_done_out.
  - th=30, tim_sum=20 -> line high for 20 cycles.
  - tim_sum=0 -> 1-cycle period with bit_done_out at j=0.
- rst_req_in with rst_cnt_in=2500 from IDLE -> line low 2500 cycles; rst_done_out at cycle 2499; a bit_rdy_in in that cycle starts a bit at the next cycle.
- bit_rdy_in at j=5 of a 25-cycle bit -> ignored, timing unchanged; proto_err_out=1 with WS281X_CODE_ERR_EN defined, 0 without. Same cycle bit_rdy_in+rst_req_in from IDLE -> bit sent, no RST state entered.
- rst_n_in asserted mid-bit (j=3, line high) -> bit_code_out=0 and busy_out=0 immediately; after release, the block is IDLE and accepts a new bit normally.
